// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO that feeds a UART transmitter. The CPU/bus side
//                pushes bytes with wr_en. A three-state launcher pops one
//                byte at a time, presents it on tx_data and pulses tx_en. It
//                then waits for the transmitter to go busy and return to idle
//                before it launches the next byte.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH      number of byte entries (power of two, 2..64)
//    CW         width of count, log2(DEPTH)+1
//  Ports
//    clk        in   1   system clock, rising edge
//    rst        in   1   asynchronous reset, active low
//    wr_en      in   1   write strobe, one byte per high cycle
//    wr_data    in   8   byte to store
//    full       out  1   count == DEPTH
//    empty      out  1   count == 0
//    count      out  CW  number of stored bytes
//    overflow   out  1   sticky: a write was attempted while full
//    ovf_clr    in   1   clears overflow (a new overflow in the same cycle wins)
//    tx_data    out  8   byte presented to the transmitter DATA input
//    tx_en      out  1   one-cycle launch pulse to the transmitter EN input
//    tx_status  in   1   transmitter STATUS, 1 = idle, 0 = busy
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [7:0]    tx_data,
  output logic          tx_en,
  input  logic          tx_status
);

  localparam int            c_addr_w    = $clog2(DEPTH);
  localparam logic [c_addr_w-1:0] c_ptr_one   = c_addr_w'(1);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [CW-1:0] c_cnt_depth = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // Storage and bookkeeping
  logic [7:0]          r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_overflow;

  // Launcher
  state_t              r_state;
  logic [7:0]          r_tx_data;
  logic                r_tx_en;

  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_count_nxt;

  // Both decisions use the registered flags: a write into a full FIFO is
  // refused even if a pop frees a slot in the same cycle, and a pop only
  // ever sees bytes stored on an earlier edge.
  assign w_push = wr_en & ~r_full;
  assign w_pop  = (r_state == ST_IDLE) & ~r_empty & tx_status;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  // Byte storage carries no reset; stale contents are never read because
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_cnt_depth);
      r_empty <= (w_count_nxt == '0);
      // Set has priority over clear.
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Launcher: pop in IDLE, then follow one full busy -> idle excursion of
  // the transmitter before considering the next byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_tx_en   <= 1'b1;
            r_state   <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!tx_status) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_status) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_data  = r_tx_data;
  assign tx_en    = r_tx_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. A queue-based model
//                predicts every output on every cycle. Directed scenarios add
//                literal expectations for single byte, burst, wrap-around,
//                full/overflow, simultaneous events and reset mid-operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  // Transmitter busy time per byte, shortened from a real baud-rate frame so
  // the run stays short; the handshake ordering is identical.
  localparam int BUSY  = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_status;

  uart_tx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  bit         m_ready;      // transmitter handshake complete, may launch
  bit         m_seen_busy;  // transmitter went busy since last launch
  bit         m_ovf;
  bit         m_tx_en;
  logic [7:0] m_tx_data;

  always @(posedge clk or negedge rst) begin : model
    bit pop;
    bit acc;
    if (!rst) begin
      m_q.delete();
      m_ready     = 1'b1;
      m_seen_busy = 1'b0;
      m_ovf       = 1'b0;
      m_tx_en     = 1'b0;
      m_tx_data   = 8'h00;
    end else begin
      pop = m_ready && (m_q.size() > 0) && (tx_status == 1'b1);
      acc = (wr_en == 1'b1) && (m_q.size() < DEPTH);
      if (wr_en && m_q.size() == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)                 m_ovf = 1'b0;
      m_tx_en = 1'b0;
      if (pop) begin
        m_tx_data   = m_q.pop_front();
        m_tx_en     = 1'b1;
        m_ready     = 1'b0;
        m_seen_busy = 1'b0;
      end else if (!m_ready) begin
        if (!m_seen_busy) begin
          if (!tx_status) m_seen_busy = 1'b1;
        end else if (tx_status) begin
          m_ready = 1'b1;
        end
      end
      if (acc) m_q.push_back(wr_data);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] log_q[$];
  logic       st_at_edge;
  int         max_count = 0;

  always @(posedge clk) begin : mon
    st_at_edge = tx_status;
    #1;
    chk("count",    32'(count),    32'(m_q.size()));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_en",    32'(tx_en),    32'(m_tx_en));
    chk("tx_data",  32'(tx_data),  32'(m_tx_data));
    if (32'(count) > 32'(max_count)) max_count = int'(count);
    if (tx_en === 1'b1) begin
      chk("launch_while_idle", 32'(st_at_edge), 32'd1);
      log_q.push_back(tx_data);
    end
  end

  // ---------------- transmitter model ----------------
  bit auto_tx;
  int busy_cnt;

  initial begin : xmit
    forever begin
      @(negedge clk);
      if (auto_tx) begin
        if (tx_en === 1'b1) busy_cnt = BUSY;
        if (busy_cnt > 0) begin
          tx_status = 1'b0;
          busy_cnt--;
        end else begin
          tx_status = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("launch_timeout", 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((m_q.size() != 0 || !m_ready || busy_cnt != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 32'(k < 3000), 32'd1);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    rst       = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    ovf_clr   = 1'b0;
    tx_status = 1'b1;
    auto_tx   = 1'b0;
    busy_cnt  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_en",    32'(tx_en),    32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);

    // Single byte: stored, then launched one cycle later
    auto_tx = 1'b1;
    log_q.delete();
    write_byte(8'hA5);
    chk("single_stored", 32'(count), 32'd1);
    @(negedge clk);
    chk("single_tx_en",   32'(tx_en),   32'd1);
    chk("single_tx_data", 32'(tx_data), 32'hA5);
    chk("single_empty",   32'(empty),   32'd1);
    @(negedge clk);
    chk("single_pulse_end", 32'(tx_en), 32'd0);
    wait_drain();

    // Burst 01..08
    log_q.delete();
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    wait_launches(8, 2000);
    for (int i = 0; i < 8; i++)
      if (i < log_q.size()) chk("burst_order", 32'(log_q[i]), 32'(i + 1));
    wait_drain();

    // Wrap-around: 20 bytes through the 8-entry buffer
    log_q.delete();
    max_count = 0;
    for (int i = 0; i < 20; i++) begin
      int k = 0;
      while (full === 1'b1 && k < 500) begin
        @(negedge clk);
        k++;
      end
      write_byte(8'(8'h30 + i * 3));
    end
    wait_launches(20, 4000);
    for (int i = 0; i < 20; i++)
      if (i < log_q.size()) chk("wrap_order", 32'(log_q[i]), 32'(8'(8'h30 + i * 3)));
    chk("wrap_reached_full", 32'(max_count), 32'd8);
    wait_drain();

    // Full / overflow with transmitter held busy
    auto_tx   = 1'b0;
    tx_status = 1'b0;
    reset_pulse();
    log_q.delete();
    for (int i = 0; i < 9; i++) begin
      write_byte(8'(8'h10 + i));
      if (i == 7) begin
        chk("full_after8",  32'(full),     32'd1);
        chk("count_after8", 32'(count),    32'd8);
        chk("ovf_after8",   32'(overflow), 32'd0);
      end
    end
    chk("ovf_after9",   32'(overflow), 32'd1);
    chk("count_after9", 32'(count),    32'd8);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Write while full in the same cycle as a pop: write dropped
    tx_status = 1'b1;
    wr_en     = 1'b1;
    wr_data   = 8'h99;
    @(negedge clk);
    wr_en = 1'b0;
    chk("simul_full_ovf",   32'(overflow), 32'd1);
    chk("simul_full_count", 32'(count),    32'd7);
    chk("simul_full_tx_en", 32'(tx_en),    32'd1);
    chk("simul_full_data",  32'(tx_data),  32'h10);
    tx_status = 1'b0;
    repeat (3) @(negedge clk);
    tx_status = 1'b1;
    @(negedge clk);
    auto_tx = 1'b1;
    wait_launches(8, 2000);
    for (int i = 0; i < 8; i++)
      if (i < log_q.size()) chk("full_drain_order", 32'(log_q[i]), 32'(8'h10 + i));
    wait_drain();

    // Write and pop together at count 3
    auto_tx   = 1'b0;
    tx_status = 1'b0;
    reset_pulse();
    write_byte(8'h21);
    write_byte(8'h22);
    write_byte(8'h23);
    chk("three_count", 32'(count), 32'd3);
    tx_status = 1'b1;
    wr_en     = 1'b1;
    wr_data   = 8'h24;
    @(negedge clk);
    wr_en = 1'b0;
    chk("simul3_count", 32'(count),   32'd3);
    chk("simul3_tx_en", 32'(tx_en),   32'd1);
    chk("simul3_data",  32'(tx_data), 32'h21);
    tx_status = 1'b0;
    write_byte(8'h25);
    chk("four_count", 32'(count), 32'd4);

    // Reset mid-operation
    rst = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_tx_en", 32'(tx_en), 32'd0);
    chk("midrst_data",  32'(tx_data), 32'h00);
    @(negedge clk);
    rst       = 1'b1;
    tx_status = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_launch", 32'(tx_en), 32'd0);
    end
    write_byte(8'h5A);
    @(negedge clk);
    chk("post_rst_tx_en", 32'(tx_en),   32'd1);
    chk("post_rst_data",  32'(tx_data), 32'h5A);
    tx_status = 1'b0;
    repeat (2) @(negedge clk);
    tx_status = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
